systolic_feeder: RTL and testbench

//  Upstream stage of the MxP systolic MAC array. Buffers one A operand (MxK) and one B operand (KxP),

---
 rtl/systolic_feeder_if.sv | 15 +
 rtl/systolic_feeder.sv | 107 ++++++++++
 tb/tb_systolic_feeder.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// Operand load channel of the systolic feeder: one A column and one B row per beat,
// with a valid/ready handshake.
interface systolic_feeder_if #(
  parameter int M        = 4,
  parameter int P        = 4,
  parameter int BITWIDTH = 8
);
  logic                  iValid;
  logic                  oReady;
  logic [M*BITWIDTH-1:0] iAVec;
  logic [P*BITWIDTH-1:0] iBVec;

  modport master (output iValid, iAVec, iBVec, input oReady);
  modport slave  (input iValid, iAVec, iBVec, output oReady);
endinterface

// File: rtl/systolic_feeder.sv
// Buffers one A (MxK) and one B (KxP) operand, then streams them skewed and zero-padded into
// an MxP systolic MAC array. Optional cycle counter enabled by defining FEEDER_PERF_CNT_EN.
module systolic_feeder #(
  parameter int M        = 4,
  parameter int P        = 4,
  parameter int K        = 4,
  parameter int BITWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  systolic_feeder_if.slave      loadBus,
  output logic [M*BITWIDTH-1:0] oRow,
  output logic [P*BITWIDTH-1:0] oCol,
  output logic                  oArrayRstN,
  output logic                  oBusy,
  output logic                  oDone
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]           oCycleCnt
`endif
);

  localparam int S  = K + M + P - 2;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int TW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {LOAD, CLEAR, STREAM, DONE} state_t;

  state_t                state, nextState;
  logic [KW-1:0]         beatCnt;
  logic [TW-1:0]         t;
  logic [BITWIDTH-1:0]   aBuf [K][M];
  logic [BITWIDTH-1:0]   bBuf [K][P];
  logic                  accept;

  assign accept         = loadBus.iValid && (state == LOAD);
  assign loadBus.oReady = (state == LOAD);
  assign oArrayRstN     = (state != CLEAR);
  assign oBusy          = (state == CLEAR) || (state == STREAM);
  assign oDone          = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= LOAD;
      beatCnt <= '0;
      t       <= '0;
    end else begin
      state <= nextState;
      if (accept)
        beatCnt <= (beatCnt == KW'(K - 1)) ? '0 : beatCnt + 1'b1;
      if (state == STREAM)
        t <= (t == TW'(S - 1)) ? '0 : t + 1'b1;
    end
  end

  // NOTE: operand buffers carry no reset; they are always fully rewritten before STREAM reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < M; i++)
        aBuf[beatCnt][i] <= loadBus.iAVec[(M-1-i)*BITWIDTH +: BITWIDTH];
      for (int j = 0; j < P; j++)
        bBuf[beatCnt][j] <= loadBus.iBVec[(P-1-j)*BITWIDTH +: BITWIDTH];
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    unique case (state)
      LOAD:    if (accept && beatCnt == KW'(K - 1)) nextState = CLEAR;
      CLEAR:   nextState = STREAM;
      STREAM:  if (t == TW'(S - 1)) nextState = DONE;
      DONE:    nextState = LOAD;
      default: nextState = LOAD;
    endcase
  end

  // Row i lags by i cycles and column j by j cycles so matching k terms meet in PE(i,j).
  always_comb begin
    oRow = '0;
    oCol = '0;
    if (state == STREAM) begin
      for (int i = 0; i < M; i++)
        if (int'(t) >= i && int'(t) - i < K)
          oRow[(M-1-i)*BITWIDTH +: BITWIDTH] = aBuf[KW'(int'(t) - i)][i];
      for (int j = 0; j < P; j++)
        if (int'(t) >= j && int'(t) - j < K)
          oCol[(P-1-j)*BITWIDTH +: BITWIDTH] = bBuf[KW'(int'(t) - j)][j];
    end
  end

`ifdef FEEDER_PERF_CNT_EN
  // Runs from the first accepted beat through DONE; idle LOAD with no beats holds the value.
  logic counting;
  assign counting = (state != LOAD) || (beatCnt != '0);

  always_ff @(posedge clk) begin
    if (!reset)
      oCycleCnt <= '0;
    else if (accept && beatCnt == '0)
      oCycleCnt <= 32'd1;
    else if (counting && oCycleCnt != '1)
      oCycleCnt <= oCycleCnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: scoreboard of expected skewed streams and products,
// with a behavioural MxP systolic MAC array fed from the feeder outputs.
module tb_systolic_feeder;
  localparam int M  = 4;
  localparam int P  = 4;
  localparam int K  = 4;
  localparam int BW = 8;
  localparam int S  = K + M + P - 2;

  typedef logic [BW-1:0] aMat_t [M][K];
  typedef logic [BW-1:0] bMat_t [K][P];

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if #(.M(M), .P(P), .BITWIDTH(BW)) ifc ();
  logic [M*BW-1:0] oRow;
  logic [P*BW-1:0] oCol;
  logic            oArrayRstN, oBusy, oDone;
`ifdef FEEDER_PERF_CNT_EN
  logic [31:0]     oCycleCnt;
`endif

  systolic_feeder #(.M(M), .P(P), .K(K), .BITWIDTH(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .loadBus    (ifc),
    .oRow       (oRow),
    .oCol       (oCol),
    .oArrayRstN (oArrayRstN),
    .oBusy      (oBusy),
    .oDone      (oDone)
`ifdef FEEDER_PERF_CNT_EN
    ,
    .oCycleCnt  (oCycleCnt)
`endif
  );

  int nChecks = 0;
  int nFails  = 0;

  logic [M*BW-1:0] rowQ [$];
  logic [P*BW-1:0] colQ [$];
  logic [31:0]     resQ [$];
  logic [M*BW-1:0] lastRow [S];
  int              lastDoneAt;

  // Behavioural array: A flows right, B flows down, one hop per cycle, accumulate on the same edge.
  logic [BW-1:0] aReg [M][P];
  logic [BW-1:0] bReg [M][P];
  logic [31:0]   acc  [M][P];

  always @(posedge clk) begin
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < P; j++) begin
        logic [BW-1:0] aIn, bIn;
        if (j == 0) aIn = oRow[(M-1-i)*BW +: BW];
        else        aIn = aReg[i][j-1];
        if (i == 0) bIn = oCol[(P-1-j)*BW +: BW];
        else        bIn = bReg[i-1][j];
        if (!oArrayRstN) begin
          acc[i][j]  <= '0;
          aReg[i][j] <= '0;
          bReg[i][j] <= '0;
        end else begin
          acc[i][j]  <= acc[i][j] + 32'(aIn) * 32'(bIn);
          aReg[i][j] <= aIn;
          bReg[i][j] <= bIn;
        end
      end
    end
  end

  function automatic void pushJob(input aMat_t a, input bMat_t b);
    logic [M*BW-1:0] row;
    logic [P*BW-1:0] col;
    logic [31:0]     sum;
    for (int tt = 0; tt < S; tt++) begin
      row = '0;
      col = '0;
      for (int i = 0; i < M; i++)
        if (tt - i >= 0 && tt - i < K) row[(M-1-i)*BW +: BW] = a[i][tt-i];
      for (int j = 0; j < P; j++)
        if (tt - j >= 0 && tt - j < K) col[(P-1-j)*BW +: BW] = b[tt-j][j];
      rowQ.push_back(row);
      colQ.push_back(col);
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) begin
        sum = '0;
        for (int kk = 0; kk < K; kk++) sum += 32'(a[i][kk]) * 32'(b[kk][j]);
        resQ.push_back(sum);
      end
  endfunction

  // Drives K beats; leaves the last beat on the bus with iValid still high.
  task automatic loadMatrix(input aMat_t a, input bMat_t b, input int gapAt, input int gapLen);
    int waits;
    for (int kk = 0; kk < K; kk++) begin
      if (kk == gapAt)
        for (int g = 0; g < gapLen; g++) begin
          @(negedge clk);
          ifc.iValid = 1'b0;
        end
      @(negedge clk);
      waits = 0;
      while (!ifc.oReady && waits < 50) begin
        @(negedge clk);
        waits++;
      end
      nChecks++;
      if (!ifc.oReady) begin
        nFails++;
        $display("FAIL load_ready_timeout beat=%0d oReady=%b required 1", kk, ifc.oReady);
      end
      for (int i = 0; i < M; i++) ifc.iAVec[(M-1-i)*BW +: BW] = a[i][kk];
      for (int j = 0; j < P; j++) ifc.iBVec[(P-1-j)*BW +: BW] = b[kk][j];
      ifc.iValid = 1'b1;
    end
    pushJob(a, b);
  endtask

  // Follows one CLEAR/STREAM/DONE sequence; ends at the DONE cycle's sample point.
  task automatic runJob(input bit keepValid);
    int              cyc;
    logic [M*BW-1:0] expRow;
    logic [P*BW-1:0] expCol;
    logic [31:0]     expRes;
    cyc = 1;
    @(negedge clk);
    if (keepValid) begin
      ifc.iAVec = (M*BW)'($urandom);
      ifc.iBVec = (P*BW)'($urandom);
    end else begin
      ifc.iValid = 1'b0;
    end
    while (oArrayRstN && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    nChecks++;
    if ({oArrayRstN, oReady_q(), oBusy, oDone, oRow, oCol} !== {4'b0010, {(M*BW){1'b0}}, {(P*BW){1'b0}}}) begin
      nFails++;
      $display("FAIL clear_cycle rstn/ready/busy/done=%b%b%b%b row=%h col=%h required 0010 0 0",
               oArrayRstN, oReady_q(), oBusy, oDone, oRow, oCol);
      return;
    end
    for (int tt = 0; tt < S; tt++) begin
      @(negedge clk);
      cyc++;
      if (keepValid) begin
        ifc.iAVec = (M*BW)'($urandom);
        ifc.iBVec = (P*BW)'($urandom);
      end
      lastRow[tt] = oRow;
      expRow = (rowQ.size() > 0) ? rowQ.pop_front() : 'x;
      expCol = (colQ.size() > 0) ? colQ.pop_front() : 'x;
      nChecks++;
      if ({oArrayRstN, oReady_q(), oBusy, oDone} !== 4'b1010) begin
        nFails++;
        $display("FAIL stream_status t=%0d rstn/ready/busy/done=%b%b%b%b required 1010",
                 tt, oArrayRstN, oReady_q(), oBusy, oDone);
      end
      nChecks++;
      if (oRow !== expRow || oCol !== expCol) begin
        nFails++;
        $display("FAIL stream_data t=%0d row=%h col=%h required row=%h col=%h",
                 tt, oRow, oCol, expRow, expCol);
      end
    end
    @(negedge clk);
    cyc++;
    lastDoneAt = cyc;
    nChecks++;
    if ({oArrayRstN, oReady_q(), oBusy, oDone, oRow, oCol} !== {4'b1001, {(M*BW){1'b0}}, {(P*BW){1'b0}}}) begin
      nFails++;
      $display("FAIL done_cycle rstn/ready/busy/done=%b%b%b%b row=%h col=%h required 1001 0 0",
               oArrayRstN, oReady_q(), oBusy, oDone, oRow, oCol);
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) begin
        expRes = (resQ.size() > 0) ? resQ.pop_front() : 'x;
        nChecks++;
        if (acc[i][j] !== expRes) begin
          nFails++;
          $display("FAIL array_result (%0d,%0d) got %0d required %0d", i, j, acc[i][j], expRes);
        end
      end
  endtask

  function automatic logic oReady_q();
    return ifc.oReady;
  endfunction

  task automatic checkIdle(input string name);
    nChecks++;
    if ({ifc.oReady, oArrayRstN, oBusy, oDone, oRow, oCol} !== {4'b1100, {(M*BW){1'b0}}, {(P*BW){1'b0}}}) begin
      nFails++;
      $display("FAIL %s ready/rstn/busy/done=%b%b%b%b row=%h col=%h required 1100 0 0",
               name, ifc.oReady, oArrayRstN, oBusy, oDone, oRow, oCol);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ifc.iValid = 1'b0;
    ifc.iAVec = '0;
    ifc.iBVec = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checkIdle("reset_outputs");
    @(negedge clk);
    checkIdle("idle_after_reset");
  endtask

  task automatic test_skew();
    aMat_t a;
    bMat_t b;
    for (int i = 0; i < M; i++) for (int kk = 0; kk < K; kk++) a[i][kk] = BW'(kk + 1);
    for (int kk = 0; kk < K; kk++) for (int j = 0; j < P; j++) b[kk][j] = BW'(kk + 1);
    loadMatrix(a, b, -1, 0);
    runJob(1'b0);
    nChecks++;
    if (lastRow[0] !== 32'h01000000 || lastRow[1] !== 32'h02010000 ||
        lastRow[3] !== 32'h04030201 || lastRow[9] !== 32'h0) begin
      nFails++;
      $display("FAIL skew_rows t0=%h t1=%h t3=%h t9=%h required 01000000 02010000 04030201 00000000",
               lastRow[0], lastRow[1], lastRow[3], lastRow[9]);
    end
    @(negedge clk);
    checkIdle("after_skew");
  endtask

  task automatic test_matmul(input string name);
    aMat_t a;
    bMat_t b;
    for (int i = 0; i < M; i++) for (int kk = 0; kk < K; kk++) a[i][kk] = (i == kk) ? 8'd1 : 8'd0;
    for (int kk = 0; kk < K; kk++) for (int j = 0; j < P; j++) b[kk][j] = BW'(4 * kk + j + 1);
    loadMatrix(a, b, -1, 0);
    runJob(1'b0);
    nChecks++;
    if (lastDoneAt !== S + 2) begin
      nFails++;
      $display("FAIL %s_done_latency got %0d cycles required %0d", name, lastDoneAt, S + 2);
    end
    @(negedge clk);
    checkIdle({name, "_after_done"});
`ifdef FEEDER_PERF_CNT_EN
    nChecks++;
    if (oCycleCnt !== 32'd16) begin
      nFails++;
      $display("FAIL %s_cycle_count got %0d required 16", name, oCycleCnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    aMat_t a1, a2;
    bMat_t b1, b2;
    for (int i = 0; i < M; i++) for (int kk = 0; kk < K; kk++) begin
      a1[i][kk] = BW'($urandom);
      a2[i][kk] = BW'($urandom);
    end
    for (int kk = 0; kk < K; kk++) for (int j = 0; j < P; j++) begin
      b1[kk][j] = BW'($urandom);
      b2[kk][j] = BW'($urandom);
    end
    loadMatrix(a1, b1, -1, 0);
    runJob(1'b1);
    loadMatrix(a2, b2, -1, 0);
    runJob(1'b0);
    @(negedge clk);
    checkIdle("after_back_to_back");
  endtask

  task automatic test_reset_mid_op();
    aMat_t a;
    bMat_t b;
    for (int i = 0; i < M; i++) for (int kk = 0; kk < K; kk++) a[i][kk] = BW'($urandom);
    for (int kk = 0; kk < K; kk++) for (int j = 0; j < P; j++) b[kk][j] = BW'($urandom);
    loadMatrix(a, b, -1, 0);
    @(negedge clk);
    ifc.iValid = 1'b0;
    repeat (4) @(negedge clk);
    nChecks++;
    if (oBusy !== 1'b1) begin
      nFails++;
      $display("FAIL midop_busy got %b required 1", oBusy);
    end
    reset = 1'b0;
    @(negedge clk);
    checkIdle("reset_mid_stream");
    reset = 1'b1;
    rowQ.delete();
    colQ.delete();
    resQ.delete();
    test_matmul("reload");
  endtask

`ifdef FEEDER_PERF_CNT_EN
  task automatic test_perf_gap();
    aMat_t a;
    bMat_t b;
    for (int i = 0; i < M; i++) for (int kk = 0; kk < K; kk++) a[i][kk] = BW'($urandom);
    for (int kk = 0; kk < K; kk++) for (int j = 0; j < P; j++) b[kk][j] = BW'($urandom);
    loadMatrix(a, b, 2, 2);
    runJob(1'b0);
    @(negedge clk);
    nChecks++;
    if (oCycleCnt !== 32'd18) begin
      nFails++;
      $display("FAIL gap_cycle_count got %0d required 18", oCycleCnt);
    end
    @(negedge clk);
    nChecks++;
    if (oCycleCnt !== 32'd18) begin
      nFails++;
      $display("FAIL cycle_count_hold got %0d required 18", oCycleCnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit reached");
  end

  initial begin
    test_reset();
    test_skew();
    test_matmul("matmul");
    test_back_to_back();
    test_reset_mid_op();
`ifdef FEEDER_PERF_CNT_EN
    test_perf_gap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
